// File: rtl/distortion_pkg.sv
// rtl/distortion_pkg.sv - shared types and constants for the distortion scheduler
package distortion_pkg;
  localparam int CRUSH_LATENCY = 2;
  localparam int CFG_SHIFT_W   = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic                   enable;
    logic [CFG_SHIFT_W-1:0] shift;
  } track_cfg_t;
endpackage

// File: rtl/crush_unit.sv
// rtl/crush_unit.sv - two-stage bit-crush pipeline carrying valid/tag alongside the sample
module crush_unit #(
  parameter int WIDTH   = 16,
  parameter int SHIFT_W = 4,
  parameter int TAG_W   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic [TAG_W-1:0]   i_tag,
  input  logic               i_enable,
  input  logic [SHIFT_W-1:0] i_shift,
  input  logic [WIDTH-1:0]   i_data,
  output logic               o_valid,
  output logic [TAG_W-1:0]   o_tag,
  output logic [WIDTH-1:0]   o_data
);
  localparam int MAX_S = WIDTH - 1;

  logic [SHIFT_W-1:0]       w_shift;
  logic signed [WIDTH-1:0]  w_sdata;
  logic [WIDTH-1:0]         w_asr;

  logic                     r_s1_valid;
  logic [TAG_W-1:0]         r_s1_tag;
  logic                     r_s1_en;
  logic [SHIFT_W-1:0]       r_s1_shift;
  logic [WIDTH-1:0]         r_s1_data;
  logic                     r_s2_valid;
  logic [TAG_W-1:0]         r_s2_tag;
  logic [WIDTH-1:0]         r_s2_data;

  // Keep the arithmetic shift in its own signed expression so the sign bit is replicated
  always_comb begin
    w_shift = i_shift;
    if (32'(i_shift) > MAX_S) w_shift = SHIFT_W'(MAX_S);
    w_sdata = i_data;
    w_asr   = w_sdata >>> w_shift;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= i_valid;
      r_s2_valid <= r_s1_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    r_s1_tag   <= i_tag;
    r_s1_en    <= i_enable;
    r_s1_shift <= w_shift;
    r_s1_data  <= i_enable ? w_asr : i_data;
    r_s2_tag   <= r_s1_tag;
    r_s2_data  <= r_s1_en ? (r_s1_data << r_s1_shift) : r_s1_data;
  end

  assign o_valid = r_s2_valid;
  assign o_tag   = r_s2_tag;
  assign o_data  = r_s2_data;
endmodule

// File: rtl/distortion_scheduler.sv
// rtl/distortion_scheduler.sv - time-multiplexes one crush datapath across all mixer tracks
module distortion_scheduler
  import distortion_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int N_TRACKS = 4,
  parameter int SHIFT_W  = CFG_SHIFT_W
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         sample_in_valid,
  input  logic [N_TRACKS*WIDTH-1:0]    samples_in,
  input  logic                         cfg_we,
  input  logic [$clog2(N_TRACKS)-1:0]  cfg_track,
  input  logic                         cfg_enable,
  input  logic [SHIFT_W-1:0]           cfg_shift,
  output logic [N_TRACKS*WIDTH-1:0]    samples_out,
  output logic                         samples_out_valid,
  output logic                         busy,
  output logic                         dropped
);
  localparam int TRK_W = $clog2(N_TRACKS);
  localparam int DR_W  = (CRUSH_LATENCY > 1) ? $clog2(CRUSH_LATENCY) : 1;

  state_t                       r_state, w_next_state;
  logic [TRK_W-1:0]             r_cnt;
  logic [DR_W-1:0]              r_drain;
  logic [WIDTH-1:0]             r_frame_buf  [N_TRACKS];
  logic [WIDTH-1:0]             r_result_buf [N_TRACKS];
  track_cfg_t                   r_pending    [N_TRACKS];
  track_cfg_t                   r_active     [N_TRACKS];
  logic [N_TRACKS*WIDTH-1:0]    r_samples_out;
  logic                         r_out_valid;
  logic                         r_dropped;

  logic                         w_accept;
  logic                         w_cu_valid;
  logic [TRK_W-1:0]             w_cu_tag;
  logic [WIDTH-1:0]             w_cu_data;

  assign w_accept = (r_state == IDLE) && sample_in_valid;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (sample_in_valid) w_next_state = ISSUE;
      ISSUE:   if (r_cnt == TRK_W'(N_TRACKS - 1)) w_next_state = DRAIN;
      DRAIN:   if (r_drain == DR_W'(CRUSH_LATENCY - 1)) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // Pending config is written with <= so a same-cycle accept copies the pre-write value
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_cnt         <= '0;
      r_drain       <= '0;
      r_samples_out <= '0;
      r_out_valid   <= 1'b0;
      r_dropped     <= 1'b0;
      for (int k = 0; k < N_TRACKS; k++) begin
        r_pending[k] <= '0;
        r_active[k]  <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      r_dropped   <= sample_in_valid && (r_state != IDLE);
      if (cfg_we && (32'(cfg_track) < N_TRACKS))
        r_pending[cfg_track] <= '{enable: cfg_enable, shift: CFG_SHIFT_W'(cfg_shift)};
      case (r_state)
        IDLE: begin
          if (sample_in_valid) begin
            r_cnt <= '0;
            for (int k = 0; k < N_TRACKS; k++) r_active[k] <= r_pending[k];
          end
        end
        ISSUE: begin
          r_cnt   <= r_cnt + 1'b1;
          r_drain <= '0;
        end
        DRAIN: r_drain <= r_drain + 1'b1;
        DONE: begin
          for (int k = 0; k < N_TRACKS; k++)
            r_samples_out[k*WIDTH +: WIDTH] <= r_result_buf[k];
          r_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_accept)
      for (int k = 0; k < N_TRACKS; k++) r_frame_buf[k] <= samples_in[k*WIDTH +: WIDTH];
    if (w_cu_valid) r_result_buf[w_cu_tag] <= w_cu_data;
  end

  crush_unit #(
    .WIDTH   (WIDTH),
    .SHIFT_W (CFG_SHIFT_W),
    .TAG_W   (TRK_W)
  ) u_crush (
    .i_clk    (clk_in),
    .i_rst_n  (rst_in),
    .i_valid  (r_state == ISSUE),
    .i_tag    (r_cnt),
    .i_enable (r_active[r_cnt].enable),
    .i_shift  (r_active[r_cnt].shift),
    .i_data   (r_frame_buf[r_cnt]),
    .o_valid  (w_cu_valid),
    .o_tag    (w_cu_tag),
    .o_data   (w_cu_data)
  );

  assign samples_out       = r_samples_out;
  assign samples_out_valid = r_out_valid;
  assign busy              = (r_state != IDLE);
  assign dropped           = r_dropped;
endmodule

// File: tb/tb_distortion_scheduler.sv
// tb/tb_distortion_scheduler.sv - self-checking bench for distortion_scheduler
module tb_distortion_scheduler;
  localparam int WIDTH   = 16;
  localparam int N       = 4;
  localparam int SHIFT_W = 4;
  localparam int FW      = N * WIDTH;

  logic           clk_in = 1'b0;
  logic           rst_in;
  logic           sample_in_valid;
  logic [FW-1:0]  samples_in;
  logic           cfg_we;
  logic [1:0]     cfg_track;
  logic           cfg_enable;
  logic [SHIFT_W-1:0] cfg_shift;
  logic [FW-1:0]  samples_out;
  logic           samples_out_valid;
  logic           busy;
  logic           dropped;

  int checks = 0;
  int errors = 0;
  bit m_en [N];
  int m_sh [N];
  logic [FW-1:0] out;
  logic [FW-1:0] f;

  distortion_scheduler #(.WIDTH(WIDTH), .N_TRACKS(N), .SHIFT_W(SHIFT_W)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .sample_in_valid   (sample_in_valid),
    .samples_in        (samples_in),
    .cfg_we            (cfg_we),
    .cfg_track         (cfg_track),
    .cfg_enable        (cfg_enable),
    .cfg_shift         (cfg_shift),
    .samples_out       (samples_out),
    .samples_out_valid (samples_out_valid),
    .busy              (busy),
    .dropped           (dropped)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Crushing is just clearing the low min(shift,15) bits of the sample
  function automatic logic [15:0] crush_ref(input logic [15:0] x, input bit en, input int sh);
    int s;
    logic [15:0] mask;
    s = (sh > 15) ? 15 : sh;
    mask = 16'hFFFF << s;
    return en ? (x & mask) : x;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_en[k] = 1'b0;
      m_sh[k] = 0;
    end
  endtask

  task automatic cfg_write(input int trk, input bit en, input int sh);
    cfg_we = 1'b1; cfg_track = 2'(trk); cfg_enable = en; cfg_shift = SHIFT_W'(sh);
    @(negedge clk_in);
    cfg_we = 1'b0;
    m_en[trk] = en;
    m_sh[trk] = sh;
  endtask

  task automatic run_frame(input logic [FW-1:0] frame, input int overlap_at, input bit col,
                           input int col_trk, input bit col_en, input int col_sh,
                           output logic [FW-1:0] res);
    logic [FW-1:0] exp;
    for (int k = 0; k < N; k++)
      exp[k*WIDTH +: WIDTH] = crush_ref(frame[k*WIDTH +: WIDTH], m_en[k], m_sh[k]);
    samples_in = frame;
    sample_in_valid = 1'b1;
    if (col) begin
      cfg_we = 1'b1; cfg_track = 2'(col_trk); cfg_enable = col_en; cfg_shift = SHIFT_W'(col_sh);
    end
    @(negedge clk_in);
    sample_in_valid = 1'b0;
    cfg_we = 1'b0;
    if (col) begin
      m_en[col_trk] = col_en;
      m_sh[col_trk] = col_sh;
    end
    res = '0;
    for (int i = 1; i <= N + 4; i++) begin
      check_val($sformatf("busy_c%0d", i), 64'(busy), 64'(i <= N + 3));
      check_val($sformatf("valid_c%0d", i), 64'(samples_out_valid), 64'(i == N + 4));
      check_val($sformatf("dropped_c%0d", i), 64'(dropped), 64'(overlap_at > 0 && i == overlap_at + 1));
      if (i == N + 4) begin
        check_val("frame_out", 64'(samples_out), 64'(exp));
        res = samples_out;
      end
      if (i == overlap_at) begin
        sample_in_valid = 1'b1;
        samples_in = {$urandom, $urandom};
      end
      if (i < N + 4) begin
        @(negedge clk_in);
        sample_in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    rst_in = 1'b0; sample_in_valid = 1'b0; samples_in = '0;
    cfg_we = 1'b0; cfg_track = '0; cfg_enable = 1'b0; cfg_shift = '0;
    model_reset();
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    check_val("rst_out", 64'(samples_out), 64'h0);
    check_val("rst_valid", 64'(samples_out_valid), 64'h0);
    check_val("rst_busy", 64'(busy), 64'h0);
    check_val("rst_dropped", 64'(dropped), 64'h0);

    run_frame(64'h0000_7FFF_8001_1234, 0, 1'b0, 0, 1'b0, 0, out);
    check_val("t1_passthru", 64'(out), 64'h0000_7FFF_8001_1234);

    cfg_write(1, 1'b1, 3);
    run_frame(64'hAAAA_5555_1237_0001, 0, 1'b0, 0, 1'b0, 0, out);
    check_val("t2_a", 64'(out), 64'hAAAA_5555_1230_0001);
    run_frame(64'h0102_0304_8005_FFFF, 0, 1'b0, 0, 1'b0, 0, out);
    check_val("t2_b", 64'(out), 64'h0102_0304_8000_FFFF);

    cfg_write(0, 1'b1, 15);
    run_frame(64'h1111_2222_3333_7FFF, 0, 1'b0, 0, 1'b0, 0, out);
    check_val("t3_max_pos", 64'(out), 64'h1111_2222_3330_0000);
    run_frame(64'h1111_2222_3333_C000, 0, 1'b0, 0, 1'b0, 0, out);
    check_val("t3_max_neg", 64'(out), 64'h1111_2222_3330_8000);
    cfg_write(0, 1'b1, 0);
    run_frame(64'h1111_2222_3333_1237, 0, 1'b0, 0, 1'b0, 0, out);
    check_val("t3_zero", 64'(out), 64'h1111_2222_3330_1237);

    run_frame(64'h4444_5555_6666_7777, 3, 1'b0, 0, 1'b0, 0, out);
    check_val("t4_first", 64'(out), 64'h4444_5555_6660_7777);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check_val("t4_single_valid", 64'(samples_out_valid), 64'h0);
    end

    run_frame(64'h0000_00FF_0000_0000, 0, 1'b1, 2, 1'b1, 4, out);
    check_val("t5_collide", 64'(out[47:32]), 64'h00FF);
    run_frame(64'h0000_00FF_0000_0000, 0, 1'b0, 0, 1'b0, 0, out);
    check_val("t5_after", 64'(out[47:32]), 64'h00F0);

    samples_in = 64'h9999_8888_7777_6666;
    sample_in_valid = 1'b1;
    @(negedge clk_in);
    sample_in_valid = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    model_reset();
    check_val("t6_out", 64'(samples_out), 64'h0);
    check_val("t6_busy", 64'(busy), 64'h0);
    check_val("t6_dropped", 64'(dropped), 64'h0);
    for (int i = 0; i < 10; i++) begin
      check_val("t6_no_valid", 64'(samples_out_valid), 64'h0);
      @(negedge clk_in);
    end
    run_frame(64'hF00D_8001_0007_1237, 0, 1'b0, 0, 1'b0, 0, out);
    check_val("t6_restart", 64'(out), 64'hF00D_8001_0007_1237);

    for (int it = 0; it < 30; it++) begin
      int nw;
      int ov;
      bit col;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++)
        cfg_write($urandom_range(0, N - 1), 1'($urandom), $urandom_range(0, 15));
      f = {$urandom, $urandom};
      ov = ($urandom_range(0, 3) == 0) ? $urandom_range(1, N + 3) : 0;
      col = ($urandom_range(0, 3) == 0);
      run_frame(f, ov, col, $urandom_range(0, N - 1), 1'($urandom), $urandom_range(0, 15), out);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/distortion_scheduler.md
# distortion_scheduler

Time-multiplexes one shared bit-crush/distortion datapath across N_TRACKS mixer tracks. Each audio frame (one sample per track) is latched, each track is issued in turn through a 2-stage crush pipeline with its own enable and crush depth, and the processed frame is returned as one registered vector. The block sits between the per-track sample sources and the mixer. It also owns the per-track distortion configuration, double-buffered so that changes only take effect on a frame boundary.

## Interface
- WIDTH, 16, sample width, signed two's complement
- N_TRACKS, 4, number of tracks sharing the datapath (≥2)
- SHIFT_W, 4, crush-depth field width
- clk_in  in  1  system clock (11.29 MHz); one clock domain
- rst_in  in  1  synchronous, active-low reset
- sample_in_valid  in  1  frame strobe; one-cycle pulse
- samples_in  in  N_TRACKS*WIDTH  frame; track k at bits [k*WIDTH +: WIDTH]
- cfg_we  in  1  config write strobe
- cfg_track  in  $clog2(N_TRACKS)  track index for the write
- cfg_enable  in  1  distortion enable for the track
- cfg_shift  in  SHIFT_W  crush depth (number of LSBs cleared)
- samples_out  out  N_TRACKS*WIDTH  processed frame, same packing as samples_in; held between frames
- samples_out_valid  out  1  one-cycle pulse when samples_out updates
- busy  out  1  high whenever the FSM is not in IDLE
- dropped  out  1  one-cycle pulse: a frame strobe arrived while busy

## Operation
- **FSM states:** IDLE, ISSUE, DRAIN, DONE.
  - IDLE → ISSUE on sample_in_valid. On that edge: latch samples_in into frame_buf, copy pending config to active config, clear track counter.
  - ISSUE: issue frame_buf[cnt] with active config and tag cnt into crush_unit, one track per cycle. After cnt = N_TRACKS-1, go to DRAIN.
  - DRAIN: 2 cycles, equal to CRUSH_LATENCY. Then go to DONE.
  - DONE: samples_out ← result_buf and samples_out_valid ← 1, both registered. Go to IDLE.
- **crush_unit:** enabled track → stage 1 does an arithmetic right shift by s, stage 2 does a left shift by s. Disabled track → passthrough.
  - The net effect clears the low s bits (rounding toward −∞).
  - s = min(cfg_shift, WIDTH-1).
  - Disabled tracks still take the 2-cycle path.
  - Output valid and tag select the result_buf entry to write.
- **Config writes:**
  - cfg_we writes pending[cfg_track] in any state.
  - cfg_track ≥ N_TRACKS: the write is ignored.
  - A write in the same cycle as a frame accept lands in pending only. The accepted frame uses the pre-write pending value.
- **Overlap:** sample_in_valid while busy is ignored. The frame in progress is unaffected, and dropped pulses the next cycle.
- **Reset values:**
  - Outputs: samples_out = 0, samples_out_valid = 0, busy = 0, dropped = 0.
  - FSM = IDLE.
  - Pipeline valids cleared.
  - All pending and active configs: enable = 0, shift = 0.
- **Reset mid-frame:** the frame is discarded and no samples_out_valid is produced.

## Timing
- Frame accepted in cycle t, with state IDLE and sample_in_valid = 1.
- busy = 1 for cycles t+1 … t+N_TRACKS+3.
- ISSUE runs t+1 … t+N_TRACKS. Track k is issued at t+1+k and its result is written to result_buf at the end of cycle t+3+k.
- DONE occurs at t+N_TRACKS+3.
- samples_out_valid pulses at t+N_TRACKS+4, when samples_out also changes. Total latency is N_TRACKS+4 cycles (8 for N_TRACKS = 4).
- The FSM is IDLE again at t+N_TRACKS+4; a frame strobe in that cycle is accepted.
- Minimum frame period is N_TRACKS+4 cycles. This is far below 11.29 MHz / 44.1 kHz = 256.

## Structure
- **distortion_pkg:**
  - state_t enum (IDLE, ISSUE, DRAIN, DONE)
  - CRUSH_LATENCY = 2
  - track_cfg_t struct {enable, shift[SHIFT_W]}
- **crush_unit** (sub-module): 2-stage pipeline carrying valid, tag, enable and shift through both stages. It is reusable standalone.

## Test plan
1. **Reset, all tracks disabled.** samples_in = {0x0000, 0x7FFF, 0x8001, 0x1234} (track 3 to track 0), sample_in_valid at cycle 0 → busy high cycles 1–7; samples_out_valid at cycle 8 with identical values.
2. **Track 1 distorted.** cfg_we for track 1 (enable = 1, shift = 3), then a frame with track 1 = 0x1237 → 0x1230. Next frame with track 1 = 0x8005 → 0x8000. Other tracks pass through unchanged.
3. **Maximum shift.** Track 0 shift = 15, enabled: 0x7FFF → 0x0000 and 0xC000 → 0x8000. Set shift = 0, enabled: 0x1237 → 0x1237.
4. **Overlapping strobe.** Second sample_in_valid at cycle 3 → dropped = 1 at cycle 4. Exactly one samples_out_valid at cycle 8, carrying first-frame data.
5. **Config/accept collision.** cfg_we (track 2, enable = 1, shift = 4) in the same cycle as accept, track 2 = 0x00FF → that frame outputs 0x00FF. The next frame outputs 0x00F0.
6. **Reset mid-frame.** rst_in = 0 at cycle 4 of a frame → all outputs 0 and no samples_out_valid. After release, a new frame completes normally with default (passthrough) config.
